// File: rtl/rv32_pkg.sv
// Shared RV32 fetch types and constants used by the fetch stage and its bus bundles.
package rv32_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Bus bundles for the fetch stage: instruction-memory request/response and decode handshake.
interface imem_if;
  import rv32_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err
  );

endinterface

interface id_if;
  import rv32_pkg::*;

  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic            id_fault;

  modport master (
    output id_valid, id_instr, id_pc, id_fault,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_instr, id_pc, id_fault,
    output id_ready
  );

endinterface

// File: rtl/ifetch_unit_fetch_fifo.sv
// Small synchronous FIFO with occupancy count, synchronous clear and same-cycle push/pop.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    cnt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full FIFO is only honoured when the head leaves in the same cycle.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (do_pop)  rptr_d = bump(rptr_q);
    if (do_push) wptr_d = bump(wptr_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    if (clear_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: issues imem requests at the current PC, queues returned instructions in
// order for decode, and discards in-flight fetches on a redirect.
module ifetch_unit
  import rv32_pkg::*;
#(
  parameter int QDEPTH    = 2,
  parameter int MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_stall,
  input  logic            redirect,
  imem_if.master          imem,
  id_if.master            id
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int QW = $clog2(QDEPTH + 1);
  localparam int EW = $bits(fetch_entry_t);

  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic            fblock_q, fblock_d;

  logic [OW-1:0]   live;
  logic [OW-1:0]   tag_cnt;
  logic [XLEN-1:0] tag_head;
  logic [QW-1:0]   q_cnt;
  logic [EW-1:0]   q_head_raw;
  fetch_entry_t    q_head;
  fetch_entry_t    q_wdata;

  logic            id_valid;
  logic            id_pop;
  int              occupancy;
  logic            room_ok;
  logic            credit_ok;
  logic            req;
  logic            accept;
  logic            resp_keep;
  logic            mis_fault;
  logic            q_push;

  assign live     = outst_q - drop_q;
  assign id_valid = (q_cnt != '0);
  assign id_pop   = id_valid && id.id_ready;

  // The entry leaving to decode this cycle frees its slot, which keeps k=1 fetch at 1/cycle.
  assign occupancy = int'(q_cnt) + int'(live) - int'(id_pop);
  assign room_ok   = (occupancy < QDEPTH);
  assign credit_ok = room_ok && (int'(outst_q) < MAX_OUTST);

  assign req       = !rst && !redirect && !fblock_q && (pc_in[1:0] == 2'b00) && credit_ok;
  assign accept    = req && imem.imem_gnt;
  assign resp_keep = imem.imem_rvalid && (drop_q == '0);

  // The fault entry waits until no kept fetch is in flight so the queue stays in program order.
  assign mis_fault = !rst && !redirect && !fblock_q && (pc_in[1:0] != 2'b00) &&
                     room_ok && (live == '0);
  assign q_push    = !redirect && (resp_keep || mis_fault);

  always_comb begin
    q_wdata = '{instr: NOP_INSTR, pc: pc_in, fault: 1'b1};
    if (resp_keep) begin
      q_wdata.instr = imem.imem_err ? NOP_INSTR : imem.imem_rdata;
      q_wdata.pc    = tag_head;
      q_wdata.fault = imem.imem_err;
    end
  end

  always_comb begin
    outst_d  = outst_q;
    drop_d   = drop_q;
    fblock_d = fblock_q;
    if (accept && !imem.imem_rvalid)      outst_d = outst_q + OW'(1);
    else if (!accept && imem.imem_rvalid) outst_d = outst_q - OW'(1);
    if (imem.imem_rvalid && (drop_q != '0)) drop_d = drop_q - OW'(1);
    if ((resp_keep && imem.imem_err) || mis_fault) fblock_d = 1'b1;
    if (redirect) begin
      drop_d   = outst_d;
      fblock_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_q  <= '0;
      drop_q   <= '0;
      fblock_q <= 1'b0;
    end else begin
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      fblock_q <= fblock_d;
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .push_i  (accept),
    .wdata_i (pc_in),
    .pop_i   (imem.imem_rvalid),
    .rdata_o (tag_head),
    .cnt_o   (tag_cnt)
  );

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_instr_queue (
    .clk     (clk),
    .rst     (rst),
    .clear_i (redirect),
    .push_i  (q_push),
    .wdata_i (q_wdata),
    .pop_i   (id_pop && !redirect),
    .rdata_o (q_head_raw),
    .cnt_o   (q_cnt)
  );

  assign q_head = fetch_entry_t'(q_head_raw);

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_in;
  assign pc_stall       = !accept;

  assign id.id_valid = id_valid;
  assign id.id_instr = id_valid ? q_head.instr : '0;
  assign id.id_pc    = id_valid ? q_head.pc    : '0;
  assign id.id_fault = id_valid ? q_head.fault : 1'b0;

  a_rvalid_needs_outst: assert property (@(posedge clk) disable iff (rst)
    imem.imem_rvalid |-> (outst_q != '0));
  a_gnt_needs_req: assert property (@(posedge clk) disable iff (rst)
    imem.imem_gnt |-> req);
  a_tags_track_outst: assert property (@(posedge clk) disable iff (rst)
    tag_cnt == outst_q);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a PC-register model and a fixed-latency imem model.
module tb_ifetch_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcIn;
  logic        pcStall;
  logic        redirect;

  imem_if imemBus();
  id_if   idBus();

  ifetch_unit #(
    .QDEPTH    (2),
    .MAX_OUTST (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_in    (pcIn),
    .pc_stall (pcStall),
    .redirect (redirect),
    .imem     (imemBus.master),
    .id       (idBus.master)
  );

  always #5 clk = ~clk;

  int          checkCount = 0;
  int          errCount   = 0;
  int          cycle      = 0;
  int          memLat     = 1;
  logic        gntEn      = 1'b0;
  logic        readyEn    = 1'b0;
  logic        redirectReq = 1'b0;
  logic [31:0] redirectTarget = '0;
  logic [31:0] errAddr = 32'hFFFF_FFFF;
  logic [31:0] pcModel = '0;

  logic [31:0] memAddr[$];
  int          memDue[$];
  logic [31:0] popLog[$];
  logic [31:0] acceptLog[$];

  logic        obsReq, obsStall, obsValid, obsFault, obsAccept, obsRvalid;
  logic [31:0] obsAddr, obsInstr, obsPc;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, sample, then advance the models.
  task automatic applyStimulus();
    @(negedge clk);
    pcIn           = pcModel;
    redirect       = redirectReq;
    idBus.id_ready = readyEn;
    if (!rst && memAddr.size() > 0 && memDue[0] <= cycle) begin
      imemBus.imem_rvalid = 1'b1;
      imemBus.imem_rdata  = memData(memAddr[0]);
      imemBus.imem_err    = (memAddr[0] == errAddr);
    end else begin
      imemBus.imem_rvalid = 1'b0;
      imemBus.imem_rdata  = '0;
      imemBus.imem_err    = 1'b0;
    end
    #1;
    imemBus.imem_gnt = gntEn && imemBus.imem_req;
    #1;
    obsReq    = imemBus.imem_req;
    obsAddr   = imemBus.imem_addr;
    obsStall  = pcStall;
    obsValid  = idBus.id_valid;
    obsInstr  = idBus.id_instr;
    obsPc     = idBus.id_pc;
    obsFault  = idBus.id_fault;
    obsAccept = imemBus.imem_req && imemBus.imem_gnt;
    obsRvalid = imemBus.imem_rvalid;
    @(posedge clk);
    #1;
    if (obsRvalid) begin
      void'(memAddr.pop_front());
      void'(memDue.pop_front());
    end
    if (obsAccept) begin
      memAddr.push_back(obsAddr);
      memDue.push_back(cycle + memLat);
      acceptLog.push_back(obsAddr);
    end
    if (obsValid && readyEn && !redirectReq) popLog.push_back(obsPc);
    if (redirectReq)    pcModel = redirectTarget;
    else if (!obsStall) pcModel = pcModel + 32'd4;
    cycle++;
  endtask

  task automatic doReset(input logic [31:0] startPc);
    rst         = 1'b1;
    redirectReq = 1'b0;
    errAddr     = 32'hFFFF_FFFF;
    memAddr.delete();
    memDue.delete();
    applyStimulus();
    applyStimulus();
    rst     = 1'b0;
    pcModel = startPc;
    cycle   = 0;
    popLog.delete();
    acceptLog.delete();
  endtask

  initial begin
    rst                 = 1'b1;
    pcIn                = '0;
    redirect            = 1'b0;
    imemBus.imem_gnt    = 1'b0;
    imemBus.imem_rvalid = 1'b0;
    imemBus.imem_rdata  = '0;
    imemBus.imem_err    = 1'b0;
    idBus.id_ready      = 1'b0;

    // Reset state
    applyStimulus();
    checkOutput("rst_req",   obsReq,   32'd0);
    checkOutput("rst_stall", obsStall, 32'd1);
    checkOutput("rst_valid", obsValid, 32'd0);
    checkOutput("rst_instr", obsInstr, 32'd0);
    checkOutput("rst_pc",    obsPc,    32'd0);
    checkOutput("rst_fault", obsFault, 32'd0);

    // Streaming at one instruction per cycle
    doReset(32'h0);
    memLat = 1; gntEn = 1'b1; readyEn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      applyStimulus();
      checkOutput("t1_stall", obsStall, 32'd0);
      if (c >= 2) begin
        checkOutput("t1_valid", obsValid, 32'd1);
        checkOutput("t1_pc",    obsPc,    32'((c - 2) * 4));
        checkOutput("t1_instr", obsInstr, memData(32'((c - 2) * 4)));
      end
    end

    // Decode backpressure fills the queue, then drains without loss
    doReset(32'h0);
    memLat = 1; gntEn = 1'b1; readyEn = 1'b0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus();
      if (c >= 2) begin
        checkOutput("t2_stall", obsStall, 32'd1);
        checkOutput("t2_hold",  obsInstr, memData(32'h0));
      end
    end
    checkOutput("t2_reqs", 32'(acceptLog.size()), 32'd2);
    readyEn = 1'b1;
    for (int c = 0; c < 5; c++) applyStimulus();
    checkOutput("t2_pops", 32'(popLog.size()), 32'd5);
    for (int i = 0; i < popLog.size() && i < 5; i++)
      checkOutput("t2_order", popLog[i], 32'(i * 4));

    // Redirect while two fetches are in flight
    doReset(32'h10);
    memLat = 2; gntEn = 1'b1; readyEn = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("t3_two_out", 32'(acceptLog.size()), 32'd2);
    redirectReq = 1'b1; redirectTarget = 32'h80;
    applyStimulus();
    redirectReq = 1'b0;
    applyStimulus();
    checkOutput("t3_req_new",  obsReq,  32'd1);
    checkOutput("t3_addr_new", obsAddr, 32'h80);
    for (int c = 0; c < 2; c++) begin
      applyStimulus();
      checkOutput("t3_no_stale", obsValid, 32'd0);
    end
    applyStimulus();
    checkOutput("t3_valid", obsValid, 32'd1);
    checkOutput("t3_pc",    obsPc,    32'h80);
    checkOutput("t3_instr", obsInstr, memData(32'h80));

    // Misaligned PC produces one fault entry and blocks until redirect
    doReset(32'h102);
    memLat = 1; gntEn = 1'b1; readyEn = 1'b0;
    applyStimulus();
    checkOutput("t4_req0", obsReq, 32'd0);
    applyStimulus();
    checkOutput("t4_valid", obsValid, 32'd1);
    checkOutput("t4_instr", obsInstr, NOP_INSTR);
    checkOutput("t4_pc",    obsPc,    32'h102);
    checkOutput("t4_fault", obsFault, 32'd1);
    readyEn = 1'b1;
    applyStimulus();
    for (int c = 0; c < 2; c++) begin
      applyStimulus();
      checkOutput("t4_blocked_valid", obsValid, 32'd0);
      checkOutput("t4_blocked_req",   obsReq,   32'd0);
    end
    redirectReq = 1'b1; redirectTarget = 32'h200;
    applyStimulus();
    redirectReq = 1'b0;
    checkOutput("t4_no_reqs", 32'(acceptLog.size()), 32'd0);
    applyStimulus();
    checkOutput("t4_req_new",  obsReq,   32'd1);
    checkOutput("t4_addr_new", obsAddr,  32'h200);
    checkOutput("t4_stall",    obsStall, 32'd0);

    // Bus error on the response for 0x40
    doReset(32'h40);
    memLat = 1; gntEn = 1'b1; readyEn = 1'b0;
    errAddr = 32'h40;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("t5_valid", obsValid, 32'd1);
    checkOutput("t5_fault", obsFault, 32'd1);
    checkOutput("t5_instr", obsInstr, NOP_INSTR);
    checkOutput("t5_pc",    obsPc,    32'h40);
    for (int c = 0; c < 4; c++) begin
      applyStimulus();
      checkOutput("t5_blocked_req", obsReq, 32'd0);
    end
    readyEn = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("t5_next_pc",    obsPc,    32'h44);
    checkOutput("t5_next_fault", obsFault, 32'd0);
    checkOutput("t5_next_instr", obsInstr, memData(32'h44));
    checkOutput("t5_reqs", 32'(acceptLog.size()), 32'd2);

    // Grant withheld: request held with a stable address
    doReset(32'h300);
    memLat = 1; gntEn = 1'b0; readyEn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      checkOutput("t6_req",   obsReq,   32'd1);
      checkOutput("t6_addr",  obsAddr,  32'h300);
      checkOutput("t6_stall", obsStall, 32'd1);
    end
    gntEn = 1'b1;
    applyStimulus();
    checkOutput("t6_granted", obsStall, 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
